// File: rtl/syn_bram_dp_if.sv
// rtl/syn_bram_dp_if.sv - request/response bundle for the dual-port block RAM
// Port A is read/write with byte enables, port B is read-only.
interface syn_bram_dp_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic                  en_a;
  logic [DATA_W/8-1:0]   we_a;
  logic [ADDR_W-1:0]     addr_a;
  logic [DATA_W-1:0]     din_a;
  logic [DATA_W-1:0]     dout_a;
  logic                  vld_a;
  logic                  en_b;
  logic [ADDR_W-1:0]     addr_b;
  logic [DATA_W-1:0]     dout_b;
  logic                  vld_b;
  logic                  ready;

  modport master (
    output en_a, we_a, addr_a, din_a, en_b, addr_b,
    input  dout_a, vld_a, dout_b, vld_b, ready
  );

  modport slave (
    input  en_a, we_a, addr_a, din_a, en_b, addr_b,
    output dout_a, vld_a, dout_b, vld_b, ready
  );
endinterface

// File: rtl/syn_bram_dp.sv
// rtl/syn_bram_dp.sv - self-clearing dual-port block RAM (A: byte-write R/W, B: read)
// Define SYN_BRAM_DP_OUTREG_EN for an extra output register stage (2-cycle read latency).
module syn_bram_dp #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int WR_MODE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  syn_bram_dp_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic                r_ready;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_dout_a;
  logic [DATA_W-1:0]   r_dout_b;
  logic                r_vld_a;
  logic                r_vld_b;

  logic                w_acc_a;
  logic                w_acc_b;
  logic                w_wr_a;
  logic [DATA_W-1:0]   w_old_a;
  logic [DATA_W-1:0]   w_old_b;
  logic [DATA_W-1:0]   w_merged;
  logic [DATA_W-1:0]   w_rd_a;

  assign w_acc_a = (r_state == ST_READY) && bus.en_a;
  assign w_acc_b = (r_state == ST_READY) && bus.en_b;
  assign w_wr_a  = w_acc_a && (|bus.we_a);
  assign w_old_a = r_mem[bus.addr_a];
  assign w_old_b = r_mem[bus.addr_b];

  always_comb begin
    w_merged = w_old_a;
    for (int i = 0; i < NB; i++) begin
      if (bus.we_a[i]) begin
        w_merged[i*8 +: 8] = bus.din_a[i*8 +: 8];
      end
    end
  end

  // Port B always sees the pre-write word, so only port A honours WR_MODE.
  assign w_rd_a = (WR_MODE == 1) ? w_merged : w_old_a;

  // Array has no reset; zeroing happens only through the CLEAR walk.
  always_ff @(posedge clk) begin
    if (rst_n && (r_state == ST_CLEAR)) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wr_a) begin
      r_mem[bus.addr_a] <= w_merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_CLEAR;
      r_ptr    <= '0;
      r_ready  <= 1'b0;
      r_dout_a <= '0;
      r_dout_b <= '0;
      r_vld_a  <= 1'b0;
      r_vld_b  <= 1'b0;
    end else begin
      r_vld_a <= w_acc_a;
      r_vld_b <= w_acc_b;
      if (w_acc_a) begin
        r_dout_a <= w_rd_a;
      end
      if (w_acc_b) begin
        r_dout_b <= w_old_b;
      end
      case (r_state)
        ST_CLEAR: begin
          if (r_ptr == ADDR_W'(DEPTH - 1)) begin
            r_state <= ST_READY;
            r_ready <= 1'b1;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        default: begin
          r_state <= ST_READY;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef SYN_BRAM_DP_OUTREG_EN
  logic [DATA_W-1:0] r_dout_a2;
  logic [DATA_W-1:0] r_dout_b2;
  logic              r_vld_a2;
  logic              r_vld_b2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout_a2 <= '0;
      r_dout_b2 <= '0;
      r_vld_a2  <= 1'b0;
      r_vld_b2  <= 1'b0;
    end else begin
      r_dout_a2 <= r_dout_a;
      r_dout_b2 <= r_dout_b;
      r_vld_a2  <= r_vld_a;
      r_vld_b2  <= r_vld_b;
    end
  end

  assign bus.dout_a = r_dout_a2;
  assign bus.dout_b = r_dout_b2;
  assign bus.vld_a  = r_vld_a2;
  assign bus.vld_b  = r_vld_b2;
`else
  assign bus.dout_a = r_dout_a;
  assign bus.dout_b = r_dout_b;
  assign bus.vld_a  = r_vld_a;
  assign bus.vld_b  = r_vld_b;
`endif

  assign bus.ready = r_ready;
endmodule

// File: tb/tb_syn_bram_dp.sv
// tb/tb_syn_bram_dp.sv - scoreboard bench for syn_bram_dp
// Expected words are queued at request time and matched against vld strobes.
module tb_syn_bram_dp;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 4;
  localparam int WR_MODE = 0;
`ifdef SYN_BRAM_DP_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_pass;
  int   n_rdy;
  logic [15:0] model [16];
  logic [15:0] last_a;
  logic [15:0] last_b;
  exp_t q_a [$];
  exp_t q_b [$];

  syn_bram_dp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  syn_bram_dp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WR_MODE(WR_MODE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Called just after a falling edge; request is accepted on the next rising edge.
  task automatic drive(input logic ea, input logic [1:0] wa, input logic [3:0] aa,
                       input logic [15:0] da, input logic eb, input logic [3:0] ab);
    logic [15:0] old_w;
    logic [15:0] mg;
    bus.en_a = ea; bus.we_a = wa; bus.addr_a = aa; bus.din_a = da;
    bus.en_b = eb; bus.addr_b = ab;
    old_w = model[aa];
    mg = old_w;
    if (wa[0]) mg[7:0]  = da[7:0];
    if (wa[1]) mg[15:8] = da[15:8];
    if (ea) q_a.push_back('{(WR_MODE == 1) ? mg : old_w, cyc + LAT});
    if (eb) q_b.push_back('{model[ab], cyc + LAT});
    if (ea && (wa != 2'b00)) model[aa] = mg;
    @(negedge clk);
    bus.en_a = 1'b0; bus.en_b = 1'b0; bus.we_a = 2'b00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_dout_a"}, bus.dout_a, 16'h0000);
    chk({tag, "_dout_b"}, bus.dout_b, 16'h0000);
    chk({tag, "_vld_a"}, bus.vld_a, 1'b0);
    chk({tag, "_vld_b"}, bus.vld_b, 1'b0);
    chk({tag, "_ready"}, bus.ready, 1'b0);
  endtask

  task automatic assert_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_zero_outputs(tag);
    q_a.delete();
    q_b.delete();
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    @(negedge clk);
    @(negedge clk);
  endtask

  // User traffic during CLEAR must be ignored: no strobes, no write to addr 5.
  task automatic release_and_count(output int n);
    rst_n = 1'b1;
    bus.en_a = 1'b1; bus.we_a = 2'b11; bus.addr_a = 4'd5; bus.din_a = 16'hFFFF;
    bus.en_b = 1'b1; bus.addr_b = 4'd5;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (bus.ready) break;
    end
    bus.en_a = 1'b0; bus.en_b = 1'b0; bus.we_a = 2'b00;
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 16; i++) drive(1'b1, 2'b00, 4'(i), 16'h0, 1'b1, 4'(15 - i));
    idle(LAT + 1);
    chk({tag, "_qa_drained"}, q_a.size(), 0);
    chk({tag, "_qb_drained"}, q_b.size(), 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      last_a = 16'h0;
      last_b = 16'h0;
    end else begin
      if (q_a.size() > 0 && q_a[0].due < cyc) begin
        chk("a_missing_vld", 1'b0, 1'b1);
        void'(q_a.pop_front());
      end
      if (bus.vld_a) begin
        if (q_a.size() == 0) chk("a_stray_vld", bus.vld_a, 1'b0);
        else begin
          chk("a_latency", cyc, q_a[0].due);
          chk("a_data", bus.dout_a, q_a[0].data);
          last_a = q_a[0].data;
          void'(q_a.pop_front());
        end
      end else chk("a_hold", bus.dout_a, last_a);
      if (q_b.size() > 0 && q_b[0].due < cyc) begin
        chk("b_missing_vld", 1'b0, 1'b1);
        void'(q_b.pop_front());
      end
      if (bus.vld_b) begin
        if (q_b.size() == 0) chk("b_stray_vld", bus.vld_b, 1'b0);
        else begin
          chk("b_latency", cyc, q_b[0].due);
          chk("b_data", bus.dout_b, q_b[0].data);
          last_b = q_b[0].data;
          void'(q_b.pop_front());
        end
      end else chk("b_hold", bus.dout_b, last_b);
    end
  end

  initial begin
    n_chk = 0; n_pass = 0;
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    rst_n = 1'b0;
    bus.en_a = 1'b0; bus.we_a = 2'b00; bus.addr_a = '0; bus.din_a = '0;
    bus.en_b = 1'b0; bus.addr_b = '0;
    idle(3);
    check_zero_outputs("reset");

    release_and_count(n_rdy);
    chk("ready_latency", n_rdy, 16);
    read_all("clear0");

    drive(1'b1, 2'b11, 4'd3, 16'hAABB, 1'b0, 4'd0);
    drive(1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'd3);
    drive(1'b1, 2'b01, 4'd3, 16'h1122, 1'b0, 4'd0);
    drive(1'b1, 2'b00, 4'd3, 16'h0, 1'b1, 4'd3);
    drive(1'b1, 2'b11, 4'd7, 16'h5555, 1'b1, 4'd7);
    drive(1'b0, 2'b00, 4'd0, 16'h0, 1'b1, 4'd7);
    drive(1'b1, 2'b10, 4'd9, 16'h3344, 1'b1, 4'd3);

    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            16'($urandom), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
    read_all("traffic");

    drive(1'b1, 2'b11, 4'd7, 16'hBEEF, 1'b1, 4'd3);
    drive(1'b1, 2'b00, 4'd7, 16'h0, 1'b1, 4'd7);
    idle(LAT + 1);
    chk("pre_rst_dout_b_nonzero", (bus.dout_b != 16'h0), 1'b1);
    assert_reset("rst_ready");
    release_and_count(n_rdy);
    chk("ready_latency_after_ready_rst", n_rdy, 16);
    read_all("clear1");

    drive(1'b1, 2'b11, 4'd12, 16'hC0DE, 1'b0, 4'd0);
    idle(LAT + 1);
    assert_reset("rst_pre_clear");
    rst_n = 1'b1;
    idle(8);
    assert_reset("rst_mid_clear");
    release_and_count(n_rdy);
    chk("ready_latency_after_clear_rst", n_rdy, 16);
    read_all("clear2");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
